// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet mux arbiter.
package mux_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Next round-robin start position after requester ptr, wrapping for any n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Stream bundle between N producers, the arbiter, and one downstream consumer.
interface mux_rr_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 16
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic            out_ready;
    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic [N*CW-1:0] pkt_count;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, grant_vld, grant_id, pkt_count
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, grant_vld, grant_id, pkt_count
    );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate by ptr, priority-encode, un-rotate.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic           o_any,
    output logic [IDW-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_off;
    logic [IDW:0]   w_sum;

    always_comb begin
        w_dbl = {i_req, i_req};
        w_rot = w_dbl[i_ptr +: N];
        w_off = '0;
        // Descending scan so the lowest rotated position wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (int'(w_sum) >= N) begin
            o_idx = IDW'(int'(w_sum) - N);
        end else begin
            o_idx = IDW'(w_sum);
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Packet-granular round-robin N:1 stream mux with registered grant FSM.
// Optional per-requester packet counters are built when MUX_ARB_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | no grant held; arbitrate among valid requesters
//   BUSY  | grant held on grant_id until its last beat transfers
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  arb_if
);

    localparam int IDW = $clog2(N);

    arb_state_e     r_state, w_state_nxt;
    logic [IDW-1:0] r_ptr, w_ptr_nxt;
    logic [IDW-1:0] r_grant_id, w_grant_id_nxt;
    logic           r_grant_vld, w_grant_vld_nxt;

    logic           w_any;
    logic [IDW-1:0] w_win;
    logic           w_sel_valid;
    logic           w_sel_last;
    logic [W-1:0]   w_sel_data;
    logic           w_pkt_done;

    logic           w_out_valid;
    logic [W-1:0]   w_out_data;
    logic           w_out_last;
    logic [N-1:0]   w_req_ready;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .i_req (arb_if.req_valid),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_win)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (r_grant_id == IDW'(k)) begin
                w_sel_valid = arb_if.req_valid[k];
                w_sel_last  = arb_if.req_last[k];
                w_sel_data  = arb_if.req_data[k*W +: W];
            end
        end
    end

    assign w_pkt_done = (r_state == BUSY) && w_sel_valid && arb_if.out_ready && w_sel_last;

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_grant_id_nxt  = r_grant_id;
        w_grant_vld_nxt = r_grant_vld;
        w_out_valid     = 1'b0;
        w_out_data      = '0;
        w_out_last      = 1'b0;
        w_req_ready     = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt     = BUSY;
                    w_grant_id_nxt  = w_win;
                    w_grant_vld_nxt = 1'b1;
                end
            end
            BUSY: begin
                w_out_valid = w_sel_valid;
                w_out_data  = w_sel_data;
                w_out_last  = w_sel_last;
                for (int k = 0; k < N; k++) begin
                    w_req_ready[k] = (r_grant_id == IDW'(k)) && arb_if.out_ready;
                end
                if (w_pkt_done) begin
                    w_state_nxt     = IDLE;
                    w_grant_vld_nxt = 1'b0;
                    w_ptr_nxt       = IDW'(rr_next(32'(r_grant_id), 32'(N)));
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_grant_vld <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_grant_vld <= w_grant_vld_nxt;
        end
    end

    assign arb_if.out_valid = w_out_valid;
    assign arb_if.out_data  = w_out_data;
    assign arb_if.out_last  = w_out_last;
    assign arb_if.req_ready = w_req_ready;
    assign arb_if.grant_vld = r_grant_vld;
    assign arb_if.grant_id  = r_grant_id;

`ifdef MUX_ARB_STATS_EN
    logic [CW-1:0] r_pkt_cnt [N];

    for (genvar k = 0; k < N; k++) begin : g_cnt
        // Saturating: holds at all-ones instead of wrapping.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pkt_cnt[k] <= '0;
            end else if (w_pkt_done && (r_grant_id == IDW'(k)) && (r_pkt_cnt[k] != '1)) begin
                r_pkt_cnt[k] <= r_pkt_cnt[k] + CW'(1);
            end
        end
        assign arb_if.pkt_count[k*CW +: CW] = r_pkt_cnt[k];
    end
`else
    assign arb_if.pkt_count = {(N*CW){1'b0}};
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table, directed corner cases, random vs model.
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;
`ifdef MUX_ARB_STATS_EN
    localparam int TB_CW = 4;
`else
    localparam int TB_CW = 16;
`endif
    localparam int CMAX = (1 << TB_CW) - 1;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        r;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        logic [3:0]  e_rr;
        logic        e_gv;
        logic [1:0]  e_gid;
    } vec_t;

    logic clk;
    logic rst_n;

    mux_rr_arbiter_if #(.N(N), .W(W), .CW(TB_CW)) arb_if ();

    mux_rr_arbiter #(.N(N), .W(W), .CW(TB_CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (arb_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_err;
    int n_checks;

    logic [3:0]  cur_v;
    logic [31:0] cur_d;
    logic [3:0]  cur_l;
    logic        cur_r;

    int m_owner;
    int m_last;
    int m_gid;
    int m_cnt [N];
    logic [7:0] got [$];
    vec_t tbl [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                                input logic r, input logic ov, input logic [7:0] od, input logic ol,
                                input logic [3:0] rr, input logic gv, input logic [1:0] gid);
        vec_t x;
        x.v = v; x.d = d; x.l = l; x.r = r;
        x.e_ov = ov; x.e_od = od; x.e_ol = ol; x.e_rr = rr; x.e_gv = gv; x.e_gid = gid;
        return x;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_gid   = 0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic r);
        cur_v = v; cur_d = d; cur_l = l; cur_r = r;
        arb_if.req_valid = v;
        arb_if.req_data  = d;
        arb_if.req_last  = l;
        arb_if.out_ready = r;
    endtask

    task automatic model_check();
        logic       ov, ol;
        logic [7:0] od;
        logic [3:0] rr;
        logic [63:0] cnt;
        ov = 1'b0; ol = 1'b0; od = '0; rr = '0;
        if (m_owner >= 0) begin
            ov = cur_v[m_owner];
            ol = cur_l[m_owner];
            od = cur_d[m_owner*8 +: 8];
            rr = cur_r ? (4'b0001 << m_owner) : 4'b0000;
        end
        cnt = '0;
        for (int k = 0; k < N; k++) cnt[k*TB_CW +: TB_CW] = TB_CW'(m_cnt[k]);
        chk("out_valid", 64'(arb_if.out_valid), 64'(ov));
        chk("out_data",  64'(arb_if.out_data),  64'(od));
        chk("out_last",  64'(arb_if.out_last),  64'(ol));
        chk("req_ready", 64'(arb_if.req_ready), 64'(rr));
        chk("grant_vld", 64'(arb_if.grant_vld), 64'(m_owner >= 0));
        chk("grant_id",  64'(arb_if.grant_id),  64'(m_gid));
        chk("pkt_count", 64'(arb_if.pkt_count), cnt);
        if (arb_if.out_valid && arb_if.out_ready) got.push_back(arb_if.out_data);
    endtask

    function automatic void model_advance();
        bit found;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int dd = 1; dd <= N; dd++) begin
                if (!found && cur_v[(m_last + dd) % N]) begin
                    found   = 1'b1;
                    m_owner = (m_last + dd) % N;
                    m_gid   = m_owner;
                end
            end
        end else if (cur_v[m_owner] && cur_r && cur_l[m_owner]) begin
`ifdef MUX_ARB_STATS_EN
            if (m_cnt[m_owner] < CMAX) m_cnt[m_owner]++;
`endif
            m_last  = m_owner;
            m_owner = -1;
        end
    endfunction

    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic r);
        drive(v, d, l, r);
        #4;
        model_check();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_grant_vld"}, 64'(arb_if.grant_vld), 64'd0);
        chk({tag, "_out_valid"}, 64'(arb_if.out_valid), 64'd0);
        chk({tag, "_req_ready"}, 64'(arb_if.req_ready), 64'd0);
        chk({tag, "_out_data"},  64'(arb_if.out_data),  64'd0);
        chk({tag, "_out_last"},  64'(arb_if.out_last),  64'd0);
        chk({tag, "_grant_id"},  64'(arb_if.grant_id),  64'd0);
        chk({tag, "_pkt_count"}, 64'(arb_if.pkt_count), 64'd0);
    endtask

    task automatic do_reset();
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        rst_n = 1'b0;
        #3;
        reset_checks("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        n_err = 0;
        n_checks = 0;
        model_reset();
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        rst_n = 1'b0;

        // Fairness: every requester offers a 1-beat packet each cycle.
        for (int i = 0; i < 10; i++) begin
            logic [1:0] g;
            g = 2'(i / 2);
            if (i % 2 == 0)
                tbl.push_back(mk(4'hF, 32'h33221100, 4'hF, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0,
                                 (i == 0) ? 2'd0 : 2'(g - 2'd1)));
            else
                tbl.push_back(mk(4'hF, 32'h33221100, 4'hF, 1'b1, 1'b1, 8'(g * 8'h11), 1'b1,
                                 4'b0001 << g, 1'b1, g));
        end
        tbl[9] = mk(4'hF, 32'h33221100, 4'hF, 1'b1, 1'b1, 8'h00, 1'b1, 4'b0001, 1'b1, 2'd0);
        tbl[8] = mk(4'hF, 32'h33221100, 4'hF, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd3);
        tbl.push_back(mk(4'h0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd0));
        // Single requester 2, three-beat packet A1..A3.
        tbl.push_back(mk(4'b0100, 32'h00A10000, 4'h0,    1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd0));
        tbl.push_back(mk(4'b0100, 32'h00A10000, 4'h0,    1'b1, 1'b1, 8'hA1, 1'b0, 4'b0100, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0100, 32'h00A20000, 4'h0,    1'b1, 1'b1, 8'hA2, 1'b0, 4'b0100, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0100, 32'h00A30000, 4'b0100, 1'b1, 1'b1, 8'hA3, 1'b1, 4'b0100, 1'b1, 2'd2));
        tbl.push_back(mk(4'h0,    32'h0,        4'h0,    1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd2));
        tbl.push_back(mk(4'h0,    32'h0,        4'h0,    1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd2));

        #3;
        reset_checks("por");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            #4;
            chk($sformatf("tbl%0d_out_valid", i), 64'(arb_if.out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_data", i),  64'(arb_if.out_data),  64'(tbl[i].e_od));
            chk($sformatf("tbl%0d_out_last", i),  64'(arb_if.out_last),  64'(tbl[i].e_ol));
            chk($sformatf("tbl%0d_req_ready", i), 64'(arb_if.req_ready), 64'(tbl[i].e_rr));
            chk($sformatf("tbl%0d_grant_vld", i), 64'(arb_if.grant_vld), 64'(tbl[i].e_gv));
            chk($sformatf("tbl%0d_grant_id", i),  64'(arb_if.grant_id),  64'(tbl[i].e_gid));
            @(posedge clk);
            model_advance();
            #1;
        end

        // Backpressure: five stalled cycles on beat B2 of requester 1.
        do_reset();
        got.delete();
        step(4'b0010, 32'h0000B100, 4'b0000, 1'b1);
        step(4'b0010, 32'h0000B100, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(4'b0010, 32'h0000B200, 4'b0000, 1'b0);
            #4;
            chk("bp_stall_data",  64'(arb_if.out_data),  64'hB2);
            chk("bp_stall_ready", 64'(arb_if.req_ready), 64'd0);
            model_check();
            @(posedge clk);
            model_advance();
            #1;
        end
        step(4'b0010, 32'h0000B200, 4'b0000, 1'b1);
        step(4'b0010, 32'h0000B300, 4'b0010, 1'b1);
        step(4'b0000, 32'h0, 4'b0000, 1'b1);
        chk("bp_beat_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("bp_beat0", 64'(got[0]), 64'hB1);
            chk("bp_beat1", 64'(got[1]), 64'hB2);
            chk("bp_beat2", 64'(got[2]), 64'hB3);
        end

        // Grant hold: requester 1 goes quiet mid-packet while 3 waits.
        do_reset();
        step(4'b1010, 32'hD100C100, 4'b0000, 1'b1);
        step(4'b1010, 32'hD100C100, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(4'b1000, 32'hD1000000, 4'b0000, 1'b1);
            #4;
            chk("hold_grant_id",  64'(arb_if.grant_id),  64'd1);
            chk("hold_out_valid", 64'(arb_if.out_valid), 64'd0);
            model_check();
            @(posedge clk);
            model_advance();
            #1;
        end
        step(4'b1010, 32'hD100C200, 4'b0010, 1'b1);
        step(4'b1000, 32'hD1000000, 4'b1000, 1'b1);
        drive(4'b1000, 32'hD1000000, 4'b1000, 1'b1);
        #4;
        chk("hold_next_grant", 64'(arb_if.grant_id), 64'd3);
        model_check();
        @(posedge clk);
        model_advance();
        #1;
        step(4'b0000, 32'h0, 4'b0000, 1'b1);

        // Asynchronous reset in the middle of a packet.
        do_reset();
        step(4'b0001, 32'h000000E1, 4'b0000, 1'b1);
        step(4'b0001, 32'h000000E1, 4'b0000, 1'b1);
        drive(4'b0001, 32'h000000E2, 4'b0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_grant_vld", 64'(arb_if.grant_vld), 64'd0);
        chk("async_out_valid", 64'(arb_if.out_valid), 64'd0);
        chk("async_req_ready", 64'(arb_if.req_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0000, 32'h0, 4'b0000, 1'b1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(4'($urandom_range(0, 15)), $urandom, 4'($urandom & $urandom),
                 ($urandom_range(0, 3) != 0));
        end

`ifdef MUX_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 2 * (CMAX + 5); i++) begin
            step(4'b0001, 32'h0000005A, 4'b0001, 1'b1);
        end
        chk("stats_saturated", 64'(arb_if.pkt_count[TB_CW-1:0]), 64'(CMAX));
`else
        chk("stats_absent", 64'(arb_if.pkt_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
